lcd_line_seq: RTL and testbench
===============================

LCD_LINE_SEQ -- requirements
Module: lcd_line_seq

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, byte width; LINE_BYTES, 50, data bytes per line; NUM_LINES, 240, panel lines; LINE_W, 8, line-number width.
REQ-002 Ports SHALL be, clock and reset first: i_clk in 1 sole clock (FIFO read clock); i_rst in 1 synchronous active-high reset.
REQ-003 i_start in 1 frame request; i_line_start in LINE_W first line, 1-based; i_line_count in LINE_W number of lines; i_vcom in 1 VCOM bit.
REQ-004 i_rdata in DATA_WIDTH FIFO head word, first-word fall-through; i_rempty in 1 FIFO empty; o_rinc out 1 FIFO pop strobe.
REQ-005 o_tdata out DATA_WIDTH byte to SPI shifter; o_tvalid out 1 byte valid; i_tready in 1 shifter accepts.
REQ-006 o_cs out 1 panel chip select; o_busy out 1 frame in progress; o_done out 1 one-cycle frame-complete pulse.

Function
REQ-007 A frame SHALL stream, in order: mode byte, then per line {address byte, LINE_BYTES FIFO bytes, 0x00 trailer}, then one final 0x00.
REQ-008 Mode byte SHALL be 0x80 | (i_vcom<<6), with i_vcom sampled when i_start is accepted.
REQ-009 i_start SHALL be accepted only in IDLE with i_line_count != 0; it is ignored while o_busy=1 or when i_line_count=0.
REQ-010 i_line_start and i_line_count SHALL be latched at acceptance; i_line_start of 0 or >NUM_LINES SHALL be treated as 1.
REQ-011 The address byte SHALL be the binary 1-based line number; after NUM_LINES it wraps to 1. Bit order is the shifter's concern.
REQ-012 States SHALL be IDLE, MODE, ADDR, DATA, LTRAIL, FTRAIL. IDLE->MODE on accept; MODE->ADDR; ADDR->DATA; DATA->LTRAIL after LINE_BYTES bytes; LTRAIL->ADDR if lines remain, else FTRAIL; FTRAIL->IDLE.
REQ-013 Each transition SHALL occur on the cycle the state's last byte is loaded into the output register.
REQ-014 The output register SHALL load a new byte when o_tvalid=0 or i_tready=1.
REQ-015 o_tdata SHALL be held stable while o_tvalid=1 and i_tready=0.
REQ-016 In DATA, loading SHALL require i_rempty=0. o_rinc SHALL be combinational and equal to load-enable AND DATA AND !i_rempty, giving exactly one pop per data byte.
REQ-017 FIFO empty in DATA SHALL stall the stream: no padding bytes, no pop, o_tvalid drops once the held byte is accepted. o_cs stays high.
REQ-018 Throughput SHALL be one byte per cycle with i_tready=1 and the FIFO non-empty. The first byte SHALL be valid 1 cycle after acceptance.
REQ-019 o_cs and o_busy SHALL rise the cycle after acceptance. They SHALL fall, and o_done SHALL pulse, the cycle after the final 0x00 is accepted.

Reset
REQ-020 On i_rst, the block SHALL enter IDLE with o_tdata=0, o_tvalid=0, o_cs=0, o_busy=0, o_done=0, o_rinc=0, and all counters cleared.
REQ-021 Reset mid-frame SHALL abort immediately with no o_done. Unread FIFO contents are untouched.

Structure
REQ-022 Package lcd_pkg SHALL hold the state enum, MODE_WRITE=0x80, VCOM_BIT=6 and DUMMY_BYTE=0x00.
REQ-023 The block SHALL be a single module with no sub-module. The output register, byte counter and line counter are implemented inline.

Verification (LINE_BYTES=4, NUM_LINES=8)
REQ-024 Basic frame: FIFO holds 0x10..0x17, start=3, count=2, vcom=1, tready=1. Required stream: C0,03,10,11,12,13,00,04,14,15,16,17,00,00. Required: 8 o_rinc pulses, and o_done exactly one cycle after the last accept.
REQ-025 Wrap: start=7, count=3. Required address bytes: 07,08,01. Start=0 or start=9 yields address 01 first.
REQ-026 Backpressure: i_tready alternating 1,0. Required: o_tdata stable across every stalled cycle, no lost or duplicated bytes, and a stream identical to REQ-024.
REQ-027 Underflow: FIFO empties after 2 data bytes for 5 cycles. Required: o_tvalid=0 and o_rinc=0 during the gap, o_cs=1, then the stream resumes with byte 3.
REQ-028 Reset and ignore: i_rst during DATA, then all outputs match REQ-020 next cycle. Also required: i_start while busy is ignored, and count=0 produces no o_cs and no o_done.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and fixed protocol bytes for the LCD line sequencer.
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, LTRAIL, FTRAIL} state_t;
  localparam logic [7:0] MODE_WRITE = 8'h80;
  localparam int VCOM_BIT = 6;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;
endpackage

// File: rtl/lcd_line_seq.sv
// lcd_line_seq: streams mode, per-line address/data/trailer and a final dummy byte from a FWFT FIFO to an SPI shifter.
module lcd_line_seq
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_BYTES = 50,
  parameter int NUM_LINES = 240,
  parameter int LINE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LINE_W-1:0]     i_line_start,
  input  logic [LINE_W-1:0]     i_line_count,
  input  logic                  i_vcom,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_rempty,
  output logic                  o_rinc,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_cs,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int CW = $clog2(LINE_BYTES + 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] tdata_n;
  logic tvalid_n, done_n, load, get_data;
  logic [CW-1:0] cnt, cnt_n;
  logic [LINE_W-1:0] line, line_n, left, left_n, line_nx;
  // state names the byte currently held in the output register
  assign load = !o_tvalid || i_tready;
  assign line_nx = (line == LINE_W'(NUM_LINES)) ? LINE_W'(1) : line + 1'b1;
  assign get_data = (state == ADDR) || (state == DATA && cnt != CW'(LINE_BYTES));
  assign o_rinc = load && get_data && !i_rempty;
  assign o_busy = state != IDLE;
  assign o_cs = o_busy;
  always_comb begin
    state_n = state;
    tdata_n = o_tdata;
    tvalid_n = o_tvalid;
    cnt_n = cnt;
    line_n = line;
    left_n = left;
    done_n = 1'b0;
    case (state)
      IDLE: if (i_start && i_line_count != '0) begin
        state_n = MODE;
        tdata_n = DATA_WIDTH'(MODE_WRITE | (8'(i_vcom) << VCOM_BIT));
        tvalid_n = 1'b1;
        line_n = (i_line_start == '0 || i_line_start > LINE_W'(NUM_LINES)) ? LINE_W'(1) : i_line_start;
        left_n = i_line_count;
        cnt_n = '0;
      end
      MODE: if (load) begin
        state_n = ADDR;
        tdata_n = DATA_WIDTH'(line);
      end
      ADDR, DATA: if (load) begin
        if (!get_data) begin
          state_n = LTRAIL;
          tdata_n = DATA_WIDTH'(DUMMY_BYTE);
          tvalid_n = 1'b1;
          cnt_n = '0;
        end else if (!i_rempty) begin
          state_n = DATA;
          tdata_n = i_rdata;
          tvalid_n = 1'b1;
          cnt_n = (state == ADDR) ? CW'(1) : cnt + 1'b1;
        end else tvalid_n = 1'b0;
      end
      LTRAIL: if (load) begin
        state_n = (left != LINE_W'(1)) ? ADDR : FTRAIL;
        tdata_n = (left != LINE_W'(1)) ? DATA_WIDTH'(line_nx) : DATA_WIDTH'(DUMMY_BYTE);
        line_n = (left != LINE_W'(1)) ? line_nx : line;
        left_n = left - 1'b1;
      end
      FTRAIL: if (load) begin
        state_n = IDLE;
        tvalid_n = 1'b0;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_tdata <= '0;
      o_tvalid <= 1'b0;
      o_done <= 1'b0;
      cnt <= '0;
      line <= '0;
      left <= '0;
    end else begin
      state <= state_n;
      o_tdata <= tdata_n;
      o_tvalid <= tvalid_n;
      o_done <= done_n;
      cnt <= cnt_n;
      line <= line_n;
      left <= left_n;
    end
  end
endmodule

// File: tb/tb_lcd_line_seq.sv
// tb_lcd_line_seq: randomized frame scenarios checked against a byte-stream reference model.
module tb_lcd_line_seq;
  localparam int LB = 4;
  localparam int NL = 8;
  logic clk = 0, rst = 1, start = 0, vcom = 0, tready = 1, hold_empty = 0, flush = 0;
  logic [7:0] line_start = 0, line_count = 0, tdata, rdata;
  logic rempty, rinc, tvalid, cs, busy, done;
  logic [7:0] mem [256];
  logic [7:0] rp = 0, wp = 0;
  logic [7:0] got[$], exp_q[$];
  int tot_pop = 0, tot_done = 0, cyc = 0, last_acc = 0, done_cyc = 0, stall_err = 0;
  int pass = 0, total = 0, gap_err = 0, gap_seen = 0, timeout = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;

  lcd_line_seq #(.DATA_WIDTH(8), .LINE_BYTES(LB), .NUM_LINES(NL), .LINE_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_line_start(line_start),
    .i_line_count(line_count), .i_vcom(vcom), .i_rdata(rdata), .i_rempty(rempty),
    .o_rinc(rinc), .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready),
    .o_cs(cs), .o_busy(busy), .o_done(done));

  always #5 clk = ~clk;
  assign rdata = mem[rp];
  assign rempty = (rp == wp) || hold_empty;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rp <= flush ? wp : (rinc ? rp + 8'd1 : rp);
    if (rinc) tot_pop <= tot_pop + 1;
    if (tvalid && tready) begin
      got.push_back(tdata);
      last_acc <= cyc;
    end
    if (done) begin
      tot_done <= tot_done + 1;
      done_cyc <= cyc;
    end
    if (prev_stall && (!tvalid || tdata !== prev_data)) stall_err <= stall_err + 1;
    prev_stall <= tvalid && !tready;
    prev_data <= tdata;
  end

  task automatic do_frame(input int s, input int c, input int v, input int mode,
                          input int gap_after, input int gap_len, input bit seq,
                          input logic [7:0] base, input bit inj);
    logic [7:0] dq[$];
    logic [7:0] b;
    int p0, d0, ln, gcnt;
    p0 = tot_pop; d0 = tot_done; gcnt = 0;
    got.delete(); exp_q.delete(); gap_err = 0; gap_seen = 0; timeout = 0;
    for (int i = 0; i < c * LB; i++) begin
      b = seq ? base + 8'(i) : 8'($urandom);
      mem[wp] = b; wp = wp + 8'd1; dq.push_back(b);
    end
    exp_q.push_back(8'h80 | 8'(v << 6));
    ln = (s < 1 || s > NL) ? 1 : s;
    for (int l = 0; l < c; l++) begin
      exp_q.push_back(8'(((ln - 1 + l) % NL) + 1));
      for (int k = 0; k < LB; k++) exp_q.push_back(dq[l * LB + k]);
      exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'h00);
    @(negedge clk);
    tready = 1; line_start = 8'(s); line_count = 8'(c); vcom = v[0]; start = 1;
    @(negedge clk);
    start = 0; line_start = 8'($urandom); line_count = 8'($urandom_range(1, 5)); vcom = ~vcom;
    for (int k = 0; k < 2000 && tot_done == d0; k++) begin
      tready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      start = inj && (k == 5);
      hold_empty = (tot_pop - p0 == gap_after) && (gcnt < gap_len);
      #1;
      if (hold_empty) begin
        if (rinc || !cs || (gcnt > 0 && tvalid)) gap_err++;
        gcnt++;
        gap_seen = gcnt;
      end
      @(negedge clk);
    end
    start = 0; hold_empty = 0; tready = 1;
    if (tot_done == d0) timeout = 1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if ({tdata, tvalid, cs, busy, done, rinc} !== 14'd0) $display("FAIL reset outs=%h want 0", {tdata, tvalid, cs, busy, done, rinc}); else pass++;
    rst = 0;
  endtask

  task automatic test_basic;
    int p0, d0;
    p0 = tot_pop; d0 = tot_done;
    do_frame(3, 2, 1, 0, -1, 0, 1, 8'h10, 0);
    total++; if (timeout != 0 || got != exp_q) $display("FAIL basic_stream got=%p want=%p", got, exp_q); else pass++;
    total++; if (tot_pop - p0 !== 8) $display("FAIL basic_pops got=%0d want=8", tot_pop - p0); else pass++;
    total++; if (tot_done - d0 !== 1 || done_cyc !== last_acc + 1) $display("FAIL basic_done n=%0d at=%0d want 1 at %0d", tot_done - d0, done_cyc, last_acc + 1); else pass++;
    total++; if (cs !== 0 || busy !== 0) $display("FAIL basic_idle cs=%b busy=%b want 0 0", cs, busy); else pass++;
  endtask

  task automatic test_wrap;
    do_frame(7, 3, 0, 0, -1, 0, 0, 0, 0);
    total++; if (timeout != 0 || got != exp_q) $display("FAIL wrap_stream got=%p want=%p", got, exp_q); else pass++;
    total++; if (got.size() < 13 || {got[1], got[7], got[13]} !== 24'h070801) $display("FAIL wrap_addr got=%p want 07 08 01", got); else pass++;
    do_frame(0, 1, 1, 0, -1, 0, 0, 0, 0);
    total++; if (timeout != 0 || got != exp_q || got[1] !== 8'h01) $display("FAIL start0 got=%p want=%p", got, exp_q); else pass++;
    do_frame(9, 1, 0, 0, -1, 0, 0, 0, 0);
    total++; if (timeout != 0 || got != exp_q || got[1] !== 8'h01) $display("FAIL start9 got=%p want=%p", got, exp_q); else pass++;
  endtask

  task automatic test_backpressure;
    int p0, s0;
    p0 = tot_pop; s0 = stall_err;
    do_frame(3, 2, 1, 1, -1, 0, 1, 8'h10, 0);
    total++; if (timeout != 0 || got != exp_q) $display("FAIL bp_stream got=%p want=%p", got, exp_q); else pass++;
    total++; if (stall_err - s0 !== 0) $display("FAIL bp_stable errs=%0d want 0", stall_err - s0); else pass++;
    total++; if (tot_pop - p0 !== 8) $display("FAIL bp_pops got=%0d want=8", tot_pop - p0); else pass++;
  endtask

  task automatic test_underflow;
    do_frame(5, 2, 0, 0, 2, 5, 1, 8'h40, 0);
    total++; if (timeout != 0 || got != exp_q) $display("FAIL uf_stream got=%p want=%p", got, exp_q); else pass++;
    total++; if (gap_err !== 0 || gap_seen !== 5) $display("FAIL uf_gap errs=%0d cycles=%0d want 0 5", gap_err, gap_seen); else pass++;
  endtask

  task automatic test_random;
    int s, c, p0, s0;
    for (int n = 0; n < 6; n++) begin
      s = $urandom_range(0, 10); c = $urandom_range(1, 10); p0 = tot_pop; s0 = stall_err;
      do_frame(s, c, $urandom_range(0, 1), 2, $urandom_range(0, 8), $urandom_range(0, 4), 0, 0, 0);
      total++; if (timeout != 0 || got != exp_q) $display("FAIL rand_stream s=%0d c=%0d got=%p want=%p", s, c, got, exp_q); else pass++;
      total++; if (tot_pop - p0 !== c * LB || stall_err != s0) $display("FAIL rand_pops got=%0d want=%0d stallerr=%0d", tot_pop - p0, c * LB, stall_err - s0); else pass++;
    end
  endtask

  task automatic test_ignore;
    int d0;
    do_frame(2, 2, 1, 0, -1, 0, 0, 0, 1);
    total++; if (timeout != 0 || got != exp_q) $display("FAIL busy_ignore got=%p want=%p", got, exp_q); else pass++;
    d0 = tot_done;
    @(negedge clk);
    line_count = 0; line_start = 1; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 20; k++) begin
      total++; if (cs !== 0) $display("FAIL count0_cs got=%b want 0", cs); else pass++;
      @(negedge clk);
    end
    total++; if (tot_done !== d0) $display("FAIL count0_done got=%0d want=%0d", tot_done - d0, 0); else pass++;
  endtask

  task automatic test_reset_mid;
    int p0, d0, k;
    p0 = tot_pop; d0 = tot_done;
    for (int i = 0; i < 3 * LB; i++) begin mem[wp] = 8'($urandom); wp = wp + 8'd1; end
    @(negedge clk);
    line_start = 1; line_count = 3; vcom = 1; tready = 1; start = 1;
    @(negedge clk);
    start = 0;
    for (k = 0; k < 50 && tot_pop - p0 < 2; k++) @(negedge clk);
    total++; if (tot_pop - p0 < 2) $display("FAIL rst_mid_reach pops=%0d want>=2", tot_pop - p0); else pass++;
    rst = 1;
    @(negedge clk);
    total++; if ({tdata, tvalid, cs, busy, done, rinc} !== 14'd0) $display("FAIL rst_mid outs=%h want 0", {tdata, tvalid, cs, busy, done, rinc}); else pass++;
    rst = 0; p0 = tot_pop;
    repeat (10) @(negedge clk);
    total++; if (tot_done !== d0 || tot_pop !== p0) $display("FAIL rst_mid_after done=%0d pops=%0d want 0 0", tot_done - d0, tot_pop - p0); else pass++;
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_underflow;
    test_random;
    test_ignore;
    test_reset_mid;
    test_basic;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
